load_store_unit: RTL and testbench

//  Memory-access stage directly downstream of the core's EXECUTE state: takes LOAD/STORE

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/load_aligner.sv | 33 +++
 rtl/load_store_unit.sv | 167 ++++++++++++++++
 tb/tb_load_store_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module : lsu_pkg
// Brief  : Shared types and funct3 encodings for the load/store unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } size_t;

  localparam logic [2:0] c_lb  = 3'b000;
  localparam logic [2:0] c_lh  = 3'b001;
  localparam logic [2:0] c_lw  = 3'b010;
  localparam logic [2:0] c_lbu = 3'b100;
  localparam logic [2:0] c_lhu = 3'b101;
  localparam logic [2:0] c_sb  = 3'b000;
  localparam logic [2:0] c_sh  = 3'b001;
  localparam logic [2:0] c_sw  = 3'b010;

  // funct3[1:0] carries the access width; funct3[2] only selects zero-extension.
  function automatic size_t access_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      2'b10:   return SZ_WORD;
      default: return SZ_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_aligner.sv
// ============================================================================
// Module : load_aligner
// Brief  : Shifts the addressed lane of a memory word down and sign/zero-extends it.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_aligner
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] w_shifted;
  logic        w_sign_ext;

  always_comb begin
    w_shifted  = mem_rdata >> {addr_lo, 3'b000};
    w_sign_ext = ~funct3[2];
    result     = w_shifted;
    case (access_size(funct3))
      SZ_BYTE: result = {{24{w_sign_ext & w_shifted[7]}},  w_shifted[7:0]};
      SZ_HALF: result = {{16{w_sign_ext & w_shifted[15]}}, w_shifted[15:0]};
      default: result = w_shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module : load_store_unit
// Brief  : Memory-access stage: strobe/ready bus master with alignment checks and timeout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [7:0] c_cnt_limit = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_store;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [7:0]  r_cnt;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_mem_addr;
  logic        r_mem_rstrb;
  logic [3:0]  r_mem_wmask;
  logic [31:0] r_mem_wdata;

  logic        w_accept;
  logic        w_legal;
  logic        w_aligned;
  logic        w_ok;
  logic        w_timeout;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata;
  logic [31:0] w_load_result;

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_addr   = r_mem_addr;
  assign mem_rstrb  = r_mem_rstrb;
  assign mem_wmask  = r_mem_wmask;
  assign mem_wdata  = r_mem_wdata;

  assign w_accept  = req_valid && req_ready;
  assign w_ok      = w_legal && w_aligned;
  // A ready arriving on the limit cycle takes priority over the timeout.
  assign w_timeout = (r_state == ACCESS) && !mem_ready && (r_cnt == c_cnt_limit);

  always_comb begin
    w_legal   = 1'b0;
    w_aligned = 1'b1;
    w_wmask   = 4'b0000;
    w_wdata   = req_wdata;
    if (req_store) w_legal = req_funct3 inside {c_sb, c_sh, c_sw};
    else           w_legal = req_funct3 inside {c_lb, c_lh, c_lw, c_lbu, c_lhu};
    case (access_size(req_funct3))
      SZ_BYTE: begin
        w_wmask = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_aligned = ~req_addr[0];
        w_wmask   = 4'b0011 << {req_addr[1], 1'b0};
        w_wdata   = {2{req_wdata[15:0]}};
      end
      SZ_WORD: begin
        w_aligned = (req_addr[1:0] == 2'b00);
        w_wmask   = 4'b1111;
      end
      default: ;
    endcase
  end

  load_aligner u_load_aligner (
    .mem_rdata (mem_rdata),
    .addr_lo   (r_addr_lo),
    .funct3    (r_funct3),
    .result    (w_load_result)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = w_ok ? ACCESS : RESP;
      ACCESS:  if (mem_ready || w_timeout) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_store      <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr_lo    <= 2'b00;
      r_cnt        <= 8'd0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_mem_addr   <= 32'd0;
      r_mem_rstrb  <= 1'b0;
      r_mem_wmask  <= 4'b0000;
      r_mem_wdata  <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_store    <= req_store;
            r_funct3   <= req_funct3;
            r_addr_lo  <= req_addr[1:0];
            r_cnt      <= 8'd0;
            r_resp_err <= !w_ok;
            // Rejected requests never touch the bus.
            if (w_ok) begin
              r_mem_addr  <= {req_addr[31:2], 2'b00};
              r_mem_rstrb <= !req_store;
              r_mem_wmask <= req_store ? w_wmask : 4'b0000;
              if (req_store) r_mem_wdata <= w_wdata;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            r_mem_rstrb <= 1'b0;
            r_mem_wmask <= 4'b0000;
            if (!r_store) r_resp_rdata <= w_load_result;
          end else if (w_timeout) begin
            r_mem_rstrb <= 1'b0;
            r_mem_wmask <= 4'b0000;
            r_resp_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module : tb_load_store_unit
// Brief  : Directed scoreboard bench for load_store_unit (TIMEOUT_CYCLES = 4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  int          checks;
  int          errors;
  logic [31:0] last_rdata;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_rstrb  (mem_rstrb),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // wait_n: ACCESS cycles before mem_ready is raised; negative means never.
  task automatic run_req(input string name, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int wait_n, input logic [31:0] rdata,
                         input logic exp_err, input logic [31:0] exp_load,
                         input logic [3:0] exp_wmask, input logic [31:0] exp_wdata,
                         input int exp_lat, input int exp_strobes);
    int   cyc;
    int   strobes;
    bit   done;
    exp_t e;
    exp_t got;
    @(negedge clk);
    chk({name, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    e.err   = exp_err;
    e.rdata = (st || exp_err) ? last_rdata : exp_load;
    last_rdata = e.rdata;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    cyc = 0; strobes = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      mem_ready = 1'b0;
      if (resp_valid) begin
        done = 1;
        if (sb_q.size() == 0) begin
          chk({name, ".sb_nonempty"}, 32'd0, 32'd1);
        end else begin
          got = sb_q.pop_front();
          chk({name, ".resp_err"},   {31'd0, resp_err}, {31'd0, got.err});
          chk({name, ".resp_rdata"}, resp_rdata, got.rdata);
        end
        chk({name, ".latency"}, cyc, exp_lat);
      end else if (mem_rstrb || mem_wmask != 4'b0000) begin
        strobes++;
        if (strobes == 1) begin
          chk({name, ".mem_addr"},  mem_addr, {addr[31:2], 2'b00});
          chk({name, ".mem_rstrb"}, {31'd0, mem_rstrb}, {31'd0, ~st});
          chk({name, ".mem_wmask"}, {28'd0, mem_wmask}, {28'd0, exp_wmask});
          if (st) chk({name, ".mem_wdata"}, mem_wdata, exp_wdata);
        end
        if (wait_n >= 0 && strobes > wait_n) begin
          mem_ready = 1'b1;
          mem_rdata = rdata;
        end
      end
    end
    mem_ready = 1'b0;
    chk({name, ".resp_seen"}, {31'd0, done}, 32'd1);
    chk({name, ".strobe_cycles"}, strobes, exp_strobes);
  endtask

  initial begin
    bit          saw_resp;
    checks = 0; errors = 0; last_rdata = 32'd0;
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0; mem_rdata = 32'd0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst.req_ready",  {31'd0, req_ready}, 32'd1);
    chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst.resp_err",   {31'd0, resp_err}, 32'd0);
    chk("rst.mem_rstrb",  {31'd0, mem_rstrb}, 32'd0);
    chk("rst.mem_wmask",  {28'd0, mem_wmask}, 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'd0);
    chk("rst.mem_addr",   mem_addr, 32'd0);
    chk("rst.mem_wdata",  mem_wdata, 32'd0);
    rst_n = 1'b1;

    // name st f3 addr wdata wait rdata err load wmask wdata lat strobes
    run_req("lw8",   1'b0, 3'b010, 32'h8, 32'h0, 0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 4'b0000, 32'h0, 2, 1);
    run_req("lb7",   1'b0, 3'b000, 32'h7, 32'h0, 0, 32'h80FF1234, 1'b0, 32'hFFFFFF80, 4'b0000, 32'h0, 2, 1);
    run_req("lbu7",  1'b0, 3'b100, 32'h7, 32'h0, 1, 32'h80FF1234, 1'b0, 32'h00000080, 4'b0000, 32'h0, 3, 2);
    run_req("lh2",   1'b0, 3'b001, 32'h2, 32'h0, 0, 32'h80FF1234, 1'b0, 32'hFFFF80FF, 4'b0000, 32'h0, 2, 1);
    run_req("lhu2",  1'b0, 3'b101, 32'h2, 32'h0, 2, 32'h80FF1234, 1'b0, 32'h000080FF, 4'b0000, 32'h0, 4, 3);
    run_req("lb4",   1'b0, 3'b000, 32'h4, 32'h0, 0, 32'h80FF1234, 1'b0, 32'h00000034, 4'b0000, 32'h0, 2, 1);
    run_req("sb5",   1'b1, 3'b000, 32'h5, 32'h000000AB, 0, 32'h0, 1'b0, 32'h0, 4'b0010, 32'hABABABAB, 2, 1);
    run_req("sh6",   1'b1, 3'b001, 32'h6, 32'h00001234, 1, 32'h0, 1'b0, 32'h0, 4'b1100, 32'h12341234, 3, 2);
    run_req("lw_mis",1'b0, 3'b010, 32'h2, 32'h0, 0, 32'h11111111, 1'b1, 32'h0, 4'b0000, 32'h0, 1, 0);
    run_req("ld011", 1'b0, 3'b011, 32'h0, 32'h0, 0, 32'h22222222, 1'b1, 32'h0, 4'b0000, 32'h0, 1, 0);
    run_req("st100", 1'b1, 3'b100, 32'h0, 32'h55, 0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 1, 0);
    run_req("lh_mis",1'b0, 3'b001, 32'h1, 32'h0, 0, 32'h33333333, 1'b1, 32'h0, 4'b0000, 32'h0, 1, 0);
    run_req("tmo",   1'b0, 3'b010, 32'h10, 32'h0, -1, 32'h44444444, 1'b1, 32'h0, 4'b0000, 32'h0, 5, 4);
    run_req("tmo_rdy",1'b0,3'b010, 32'h10, 32'h0, 3, 32'h13579BDF, 1'b0, 32'h13579BDF, 4'b0000, 32'h0, 5, 4);

    // Reset in the middle of a load stalled by wait states.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'hC;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid.strobe_up", {31'd0, mem_rstrb}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.rstrb",      {31'd0, mem_rstrb}, 32'd0);
    chk("mid.wmask",      {28'd0, mem_wmask}, 32'd0);
    chk("mid.req_ready",  {31'd0, req_ready}, 32'd1);
    chk("mid.resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_rdata = 32'd0;
    saw_resp = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
    end
    chk("mid.no_resp", {31'd0, saw_resp}, 32'd0);
    chk("mid.rdata",   resp_rdata, 32'd0);

    // Back-to-back: each run_req issues in the cycle right after the previous RESP.
    run_req("sw20",  1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 0, 32'h0, 1'b0, 32'h0, 4'b1111, 32'hCAFEF00D, 2, 1);
    run_req("lw20",  1'b0, 3'b010, 32'h20, 32'h0, 1, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 4'b0000, 32'h0, 3, 2);

    chk("sb_q.empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
